// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display with blanking and frame-synchronous double buffering.
// Define SEG7_LZ_BLANK_EN to suppress leading zeros on digits 3..1.
module seg7_scan_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int DIGIT_HZ  = 1_000,
    parameter int BLANK_CYC = 1_000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  digit_en_i,
    input  logic        load_i,
    output logic        upd_ack_o,
    output logic        frame_o,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o
);

    localparam int PERIOD = CLK_HZ / DIGIT_HZ;
    localparam int CTR_W  = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CTR_W-1:0] CTR_LAST  = CTR_W'(PERIOD - 1);
    localparam logic [CTR_W-1:0] CTR_BLANK = CTR_W'(BLANK_CYC);

    generate
        if (BLANK_CYC >= PERIOD || BLANK_CYC == 0) begin : g_bad_cfg
            $fatal(1, "seg7_scan_ctrl: BLANK_CYC must satisfy 1 <= BLANK_CYC < CLK_HZ/DIGIT_HZ");
        end
    endgenerate

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_e;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

`ifdef SEG7_LZ_BLANK_EN
    // A digit stays lit once any nibble at or above it is non-zero; digit 0 always stays lit.
    function automatic logic [3:0] lz_keep(input logic [15:0] v);
        logic [3:0] keep;
        keep[3] = |v[15:12];
        keep[2] = keep[3] | (|v[11:8]);
        keep[1] = keep[2] | (|v[7:4]);
        keep[0] = 1'b1;
        return keep;
    endfunction
`endif

    state_e           state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [1:0]       idx_q, idx_d;
    logic             boot_q;
    logic             pending_q, pending_d;
    logic [15:0]      shadow_val_q, shadow_val_d;
    logic [3:0]       shadow_mask_q, shadow_mask_d;
    logic [15:0]      act_val_q, act_val_d;
    logic [3:0]       act_mask_q, act_mask_d;
    logic             ctr_wrap;
    logic             frame_edge;
    logic             ack_d;
    logic [3:0]       lit_mask;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        ctr_wrap      = (ctr_q == CTR_LAST);
        ctr_d         = ctr_wrap ? '0 : ctr_q + 1'b1;
        idx_d         = ctr_wrap ? idx_q + 2'd1 : idx_q;
        frame_edge    = boot_q || (ctr_wrap && idx_q == 2'd3);
        state_d       = state_q;
        pending_d     = pending_q;
        shadow_val_d  = shadow_val_q;
        shadow_mask_d = shadow_mask_q;
        act_val_d     = act_val_q;
        act_mask_d    = act_mask_q;
        ack_d         = 1'b0;
        an_d          = 4'hF;
        seg_d         = 7'h7F;

        case (state_q)
            ST_BLANK: if (ctr_d == CTR_BLANK) state_d = ST_DRIVE;
            ST_DRIVE: if (ctr_wrap)           state_d = ST_BLANK;
            default:                          state_d = ST_BLANK;
        endcase

        // A load on the boundary cycle bypasses the shadow so it is never lost or delayed a frame.
        if (frame_edge) begin
            if (load_i) begin
                act_val_d  = value_i;
                act_mask_d = digit_en_i;
                pending_d  = 1'b0;
                ack_d      = 1'b1;
            end else if (pending_q) begin
                act_val_d  = shadow_val_q;
                act_mask_d = shadow_mask_q;
                pending_d  = 1'b0;
                ack_d      = 1'b1;
            end
        end else if (load_i) begin
            shadow_val_d  = value_i;
            shadow_mask_d = digit_en_i;
            pending_d     = 1'b1;
        end

`ifdef SEG7_LZ_BLANK_EN
        lit_mask = act_mask_d & lz_keep(act_val_d);
`else
        lit_mask = act_mask_d;
`endif

        if (state_d == ST_DRIVE) begin
            seg_d        = hex_decode(act_val_d[{idx_d, 2'b00} +: 4]);
            an_d[idx_d]  = ~lit_mask[idx_d];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_BLANK;
            ctr_q      <= '0;
            idx_q      <= 2'd0;
            boot_q     <= 1'b1;
            pending_q  <= 1'b0;
            act_val_q  <= 16'h0;
            act_mask_q <= 4'h0;
            an_o       <= 4'hF;
            seg_o      <= 7'h7F;
            upd_ack_o  <= 1'b0;
            frame_o    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            idx_q      <= idx_d;
            boot_q     <= 1'b0;
            pending_q  <= pending_d;
            act_val_q  <= act_val_d;
            act_mask_q <= act_mask_d;
            an_o       <= an_d;
            seg_o      <= seg_d;
            upd_ack_o  <= ack_d;
            frame_o    <= frame_edge;
        end
    end

    // NOTE: the shadow data registers carry no reset; pending_q alone decides whether they are ever used.
    always_ff @(posedge clk_i) begin
        shadow_val_q  <= shadow_val_d;
        shadow_mask_q <= shadow_mask_d;
    end

endmodule
